audio_fifo_sched: RTL and testbench



---
 rtl/audio_fifo_sched.sv | 158 +++++++++++++++
 tb/tb_audio_fifo_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fifo_sched.sv
// Rate-paced FIFO write scheduler: one-entry holding register, one write per div_freq tick.
// Optional underrun/overrun statistics are built when AUDIO_FIFO_SCHED_STATS_EN is defined.
module audio_fifo_sched #(
    parameter int DATA_W     = 32,
    parameter int USED_W     = 12,
    parameter int HIGH_WATER = 4032,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pause,
    input  logic              stop,
    input  logic [31:0]       div_freq,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              fifo_full,
    input  logic [USED_W-1:0] fifo_used,
    output logic              fifo_wrreq,
    output logic [DATA_W-1:0] fifo_data,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [USED_W:0] HIGH_WATER_L = (USED_W + 1)'(HIGH_WATER);

    state_t              state_q, state_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   hold_data_q;
    logic [31:0]         tick_cnt_q, tick_cnt_d;
    logic                wrreq_q, wrreq_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic abort;
    logic tick_hit;
    logic tick;
    logic can_write;
    logic do_write;
    logic xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // stop and a dropped enable both abort; they outrank any tick in the same cycle
    assign abort     = stop || !enable;
    assign tick_hit  = (div_freq <= 32'd1) || (tick_cnt_q >= div_freq - 32'd1);
    assign tick      = (state_q == RUN) && !abort && tick_hit;
    assign can_write = !fifo_full && ({1'b0, fifo_used} < HIGH_WATER_L);
    assign do_write  = tick && hold_valid_q && can_write;
    assign src_ready = (state_q != IDLE) && !hold_valid_q;
    assign xfer      = src_valid && src_ready;

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (pause) state_d = PAUSE;
                PAUSE:   if (!pause) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        hold_valid_d = hold_valid_q;
        wrreq_d      = 1'b0;
        data_d       = data_q;
        if (abort) begin
            tick_cnt_d   = 32'd0;
            hold_valid_d = 1'b0;
        end else begin
            if (state_q == RUN) begin
                tick_cnt_d = tick_hit ? 32'd0 : tick_cnt_q + 32'd1;
            end
            if (do_write) begin
                wrreq_d      = 1'b1;
                data_d       = hold_data_q;
                hold_valid_d = 1'b0;
            end else if (xfer) begin
                hold_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            tick_cnt_q   <= 32'd0;
            wrreq_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            tick_cnt_q   <= tick_cnt_d;
            wrreq_q      <= wrreq_d;
            data_q       <= data_d;
        end
    end

    // holding data is qualified by hold_valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (xfer) begin
            hold_data_q <= src_data;
        end
    end

    assign fifo_wrreq = wrreq_q;
    assign fifo_data  = data_q;
    assign state      = state_q;

`ifdef AUDIO_FIFO_SCHED_STATS_EN
    logic [CNT_W-1:0] underrun_q, underrun_d;
    logic [CNT_W-1:0] overrun_q, overrun_d;
    logic             underrun_ev;
    logic             overrun_ev;

    assign underrun_ev = tick && !hold_valid_q;
    assign overrun_ev  = tick && hold_valid_q && !can_write;

    always_comb begin
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        if (underrun_ev) underrun_d = sat_inc(underrun_q);
        if (overrun_ev)  overrun_d  = sat_inc(overrun_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_q <= '0;
            overrun_q  <= '0;
        end else begin
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign underrun_cnt = underrun_q;
    assign overrun_cnt  = overrun_q;
`else
    assign underrun_cnt = '0;
    assign overrun_cnt  = '0;
`endif

endmodule

// File: tb/tb_audio_fifo_sched.sv
// Scoreboard bench for audio_fifo_sched: expected FIFO writes (data and cycle) are queued
// by the stimulus and checked by an independent monitor; status is checked inline.
module tb_audio_fifo_sched;

    localparam int DATA_W = 32;
    localparam int USED_W = 12;
    localparam int CNT_W  = 4;
`ifdef AUDIO_FIFO_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              enable;
    logic              pause;
    logic              stop;
    logic [31:0]       div_freq;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              fifo_full;
    logic [USED_W-1:0] fifo_used;
    logic              fifo_wrreq;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        state;
    logic [CNT_W-1:0]  underrun_cnt;
    logic [CNT_W-1:0]  overrun_cnt;

    audio_fifo_sched #(
        .DATA_W(DATA_W), .USED_W(USED_W), .HIGH_WATER(4032), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pause(pause), .stop(stop),
        .div_freq(div_freq), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .fifo_full(fifo_full), .fifo_used(fifo_used),
        .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .state(state),
        .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   k;
    bit   auto_inc = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            logic x;
            x = auto_inc && src_valid && src_ready;
            @(posedge clk);
            #1;
            if (x) src_data = src_data + 1;
        end
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        src_valid = 1'b0;
        fifo_full = 1'b0;
        fifo_used = '0;
        auto_inc  = 1'b0;
        reset     = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    // monitor: every write strobe must match the head of the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fifo_wrreq === 1'b1) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_write: data %0h at cycle %0d, none expected", fifo_data, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("write_data", fifo_data, e.data);
                    chk("write_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        div_freq  = 32'd4;
        src_valid = 1'b0;
        src_data  = '0;
        fifo_full = 1'b0;
        fifo_used = '0;
        step(2);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("reset_data", fifo_data, 32'd0);
        chk("reset_ready", 32'(src_ready), 32'd0);
        chk("reset_underrun", 32'(underrun_cnt), 32'd0);
        chk("reset_overrun", 32'(overrun_cnt), 32'd0);
        reset = 1'b0;
        step(1);

        // pacing with fill level one below high water, then async reset mid-write
        div_freq  = 32'd4;
        fifo_used = 12'd4031;
        src_valid = 1'b1;
        src_data  = 32'd0;
        auto_inc  = 1'b1;
        enable    = 1'b1;
        k = cyc;
        push(32'd0, k + 5);
        push(32'd1, k + 9);
        push(32'd2, k + 13);
        push(32'd3, k + 17);
        step(1);
        chk("pace_state_run", 32'(state), 32'd1);
        chk("pace_ready_first", 32'(src_ready), 32'd1);
        step(16);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("async_reset_data", fifo_data, 32'd0);
        chk("async_reset_state", 32'(state), 32'd0);
        do_reset();

        // overrun: two ticks above high water, one with FIFO full, then drain
        div_freq  = 32'd4;
        fifo_used = 12'd4032;
        src_valid = 1'b1;
        src_data  = 32'hA0;
        enable    = 1'b1;
        k = cyc;
        step(2);
        chk("ovr_ready_held", 32'(src_ready), 32'd0);
        src_data = 32'hB0;
        step(7);
        fifo_used = 12'd0;
        fifo_full = 1'b1;
        step(4);
        fifo_full = 1'b0;
        fifo_used = 12'd100;
        chk("ovr_count", 32'(overrun_cnt), STATS ? 32'd3 : 32'd0);
        chk("ovr_ready_still_low", 32'(src_ready), 32'd0);
        chk("ovr_no_underrun", 32'(underrun_cnt), 32'd0);
        push(32'hA0, k + 17);
        step(4);
        chk("ovr_ready_freed", 32'(src_ready), 32'd1);
        push(32'hB0, k + 21);
        step(4);
        enable = 1'b0;
        step(2);
        do_reset();

        // underrun: no source data for five ticks
        div_freq  = 32'd4;
        src_valid = 1'b0;
        enable    = 1'b1;
        k = cyc;
        step(1);
        chk("und_state_run", 32'(state), 32'd1);
        step(20);
        chk("und_count", 32'(underrun_cnt), STATS ? 32'd5 : 32'd0);
        enable = 1'b0;
        step(2);
        do_reset();

        // pause mid-count delays the tick by the pause length
        div_freq  = 32'd8;
        src_valid = 1'b1;
        src_data  = 32'h55;
        enable    = 1'b1;
        k = cyc;
        step(2);
        src_data = 32'h66;
        step(2);
        pause = 1'b1;
        step(1);
        chk("pause_state_enter", 32'(state), 32'd2);
        step(9);
        chk("pause_state_hold", 32'(state), 32'd2);
        chk("pause_ready_low", 32'(src_ready), 32'd0);
        pause = 1'b0;
        step(1);
        chk("pause_state_resume", 32'(state), 32'd1);
        push(32'h55, k + 19);
        step(4);
        enable = 1'b0;
        step(2);
        do_reset();

        // stop coincident with a tick flushes the held sample
        div_freq  = 32'd4;
        src_valid = 1'b1;
        src_data  = 32'h11;
        enable    = 1'b1;
        k = cyc;
        step(4);
        stop = 1'b1;
        step(1);
        chk("stop_state_idle", 32'(state), 32'd0);
        chk("stop_ready_low", 32'(src_ready), 32'd0);
        stop     = 1'b0;
        src_data = 32'h22;
        step(1);
        chk("stop_state_rerun", 32'(state), 32'd1);
        push(32'h22, k + 10);
        step(4);
        enable = 1'b0;
        step(2);
        do_reset();

        // saturation: div_freq = 1 gives a tick every RUN cycle, 21 underruns
        div_freq  = 32'd1;
        src_valid = 1'b0;
        enable    = 1'b1;
        k = cyc;
        step(22);
        enable = 1'b0;
        step(1);
        chk("sat_underrun", 32'(underrun_cnt), STATS ? 32'd15 : 32'd0);
        chk("sat_overrun", 32'(overrun_cnt), 32'd0);
        step(2);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
